pwm_peripheral: RTL
===================

// Module: pwm_peripheral
// PURPOSE
//  Output stage downstream of the SPI register block: consumes the five control registers and drives 16 output pins.
//  Each pin is forced low, forced high, or driven by one shared 8-bit PWM waveform.
//  A prescaler sets the PWM frequency (~3 kHz at 10 MHz clk with defaults).
//  All pins share one duty cycle and one phase.
// PARAMETERS
//  PRESCALE  13  clk cycles per PWM counter step (>=1); PWM period = 256*PRESCALE clk
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   asynchronous, active-low reset
//  en_reg_out_7_0   in   8   output enable, pins 7..0 (1 = pin active)
//  en_reg_out_15_8  in   8   output enable, pins 15..8
//  en_reg_pwm_7_0   in   8   PWM select, pins 7..0 (1 = PWM, 0 = static high)
//  en_reg_pwm_15_8  in   8   PWM select, pins 15..8
//  pwm_duty_cycle   in   8   duty; high time = duty/256 of period, 0xFF = 100%
//  out              out  16  registered pin drive, out[15:8] / out[7:0]
//  period_start     out  1   one-clk pulse when the PWM counter wraps to 0
// BEHAVIOUR
//  Inputs are clk-synchronous register outputs; no synchronisers are needed.
//  Reset: out=16'h0000, period_start=0, prescaler=0, pwm_cnt=0, duty_act=0.
//  Prescaler:
//   - Counts 0..PRESCALE-1 and wraps.
//   - tick=1 for one clk when prescaler==PRESCALE-1.
//   - PRESCALE=1 gives tick every clk.
//  pwm_cnt: 8-bit, increments on tick, wraps 255->0 with no gap.
//   - period_start is registered: asserted the clk after the tick that sets pwm_cnt 255->0.
//  Level:
//   - pwm_lvl = (duty_act==8'hFF) ? 1 : (pwm_cnt < duty_act), unsigned 8-bit compare.
//   - Duty 0x00 gives constant low; 0xFF gives constant high, with no 1-step dip at cnt 255.
//  Per pin i: out_nxt[i] = en_out[i] ? (en_pwm[i] ? pwm_lvl : 1'b1) : 1'b0.
//   - out is registered from out_nxt: 1 clk latency from any input or counter change.
//  en_out=0 dominates en_pwm. Enable-register changes take effect next clk, mid-period allowed.
//  Simultaneous duty write and counter wrap: the wrap samples the pre-write duty (see CONFIGURATION).
//  Reset asserted mid-period:
//   - All state clears immediately (async); outputs low.
//   - After release the first period starts at pwm_cnt=0, and the first tick comes PRESCALE clk later.
//  No handshake: the block is free-running and always ready.
// CONFIGURATION
//  Macro PWM_SHADOW_EN.
//  Defined:
//   - duty_act is a shadow register loaded from pwm_duty_cycle only on the tick where pwm_cnt==255.
//   - A new duty takes effect at the next period boundary; no truncated or runt pulses.
//   - Loaded value = pwm_duty_cycle as sampled in that clk.
//  Undefined:
//   - duty_act = pwm_duty_cycle combinationally; a change affects the compare next clk.
//   - Mid-period glitches are accepted.
//  Enable registers are never shadowed in either mode.
// STRUCTURE
//  Package pwm_pkg:
//   - PWM_CHANNELS=16, PWM_CNT_W=8, PWM_DUTY_FULL=8'hFF
//   - typedef logic [PWM_CNT_W-1:0] pwm_cnt_t
//  Sub-module pwm_timebase:
//   - Contains prescaler and pwm_cnt.
//   - Outputs tick, pwm_cnt, wrap.
//  Top: pin mux, duty shadow (under macro), out and period_start registers.
// TESTING
//  1. Reset hold/release, all enables 0, duty 0x80 -> out==0 for 2 full periods; period_start every 256*PRESCALE clk.
//  2. en_out=16'hFFFF, en_pwm=0 -> out==16'hFFFF exactly 1 clk after enable write; stays static.
//  3. en_out=16'h0001, en_pwm=16'h0001, duty 0x40 -> out[0] high 64*PRESCALE clk of each 3328-clk period (PRESCALE=13); rises 1 clk after period_start.
//  4. Duty 0x00 -> out[0] never high. Duty 0xFF -> out[0] never low across the wrap.
//  5. Duty 0x40 -> 0xC0 written at pwm_cnt=0x80:
//   - With PWM_SHADOW_EN: current period unchanged, next period 192 steps high.
//   - Without: pin rises at next clk (cnt<0xC0).
//  6. Reset pulsed at pwm_cnt=0x90 -> out==0 within the reset; first period_start 256*PRESCALE clk after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// PWM output stage: shared types and constants.
// Used by pwm_timebase, pwm_if and pwm_peripheral.
package pwm_pkg;

   localparam int          PWM_CHANNELS  = 16;
   localparam int          PWM_CNT_W     = 8;
   localparam logic [7:0]  PWM_DUTY_FULL = 8'hFF;

   typedef logic [PWM_CNT_W-1:0]    pwm_cnt_t;
   typedef logic [PWM_CHANNELS-1:0] pwm_pins_t;

   typedef struct packed {
      pwm_pins_t en_out;
      pwm_pins_t en_pwm;
      pwm_cnt_t  duty;
   } pwm_cfg_t;

   // Full-scale duty holds the level high through count 255.
   function automatic logic pwm_level(pwm_cnt_t cnt, pwm_cnt_t duty);
      return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_if.sv
// Control register bundle from the SPI register block.
// master = register block, slave = PWM output stage.
interface pwm_if;
   import pwm_pkg::*;

   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   pwm_cnt_t   pwm_duty_cycle;

   modport master (
      output en_reg_out_7_0,
      output en_reg_out_15_8,
      output en_reg_pwm_7_0,
      output en_reg_pwm_15_8,
      output pwm_duty_cycle
   );

   modport slave (
      input en_reg_out_7_0,
      input en_reg_out_15_8,
      input en_reg_pwm_7_0,
      input en_reg_pwm_15_8,
      input pwm_duty_cycle
   );

endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler plus free-running 8-bit counter.
// tick advances the counter; wrap marks the 255->0 tick.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic     clk,
   input  logic     rst_n,
   output logic     tick,
   output pwm_cnt_t pwm_cnt,
   output logic     wrap
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] presc;

   assign tick = (presc == PS_LAST);
   assign wrap = tick && (pwm_cnt == '1);

   // Prescaler counts 0..PRESCALE-1; a single-state divider ticks every clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PS_W'(1);
   end

   // PWM counter steps once per tick and rolls 255->0 without a gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pwm_cnt <= '0;
      else if (tick)
         pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
   end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 pins forced low/high or driven by one shared PWM.
// Optional macro PWM_SHADOW_EN: duty updates only at period boundaries.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic      clk,
   input  logic      rst_n,
   pwm_if.slave      regs,
   output pwm_pins_t out,
   output logic      period_start
);

   pwm_cfg_t  cfg;
   logic      tick;
   logic      wrap;
   pwm_cnt_t  pwm_cnt;
   pwm_cnt_t  duty_act;
   logic      pwm_lvl;
   pwm_pins_t out_nxt;

   assign cfg.en_out = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
   assign cfg.en_pwm = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
   assign cfg.duty   = regs.pwm_duty_cycle;

   pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wrap    (wrap)
   );

   // A wrap is only ever the tick that leaves count 255.
   wrap_on_tick : assert property (
      @(posedge clk) disable iff (!rst_n)
      wrap |-> (tick && pwm_cnt == '1)
   );

`ifdef PWM_SHADOW_EN
   // Duty shadow: the wrap tick samples the duty seen in that clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         duty_act <= '0;
      else if (wrap)
         duty_act <= cfg.duty;
   end
`else
   assign duty_act = cfg.duty;
`endif

   // Pin mux: disabled pins are low, PWM pins follow the level.
   always_comb begin
      pwm_lvl = pwm_level(pwm_cnt, duty_act);
      out_nxt = '0;
      for (int i = 0; i < PWM_CHANNELS; i++) begin
         if (cfg.en_out[i])
            out_nxt[i] = cfg.en_pwm[i] ? pwm_lvl : 1'b1;
      end
   end

   // Registered pin drive and period marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         out          <= out_nxt;
         period_start <= wrap;
      end
   end

endmodule
